// File: rtl/dmem_port_if.sv
// Request/response bundle for one data-memory requester port.
// master = requester (CPU or debug loader), slave = dmem_arbiter.
interface dmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, we, size, addr, wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, we, size, addr, wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-addressable data RAM (p0 = CPU, p1 = debug/loader).
// Optional grant statistics outputs are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_port_if.slave        p0,
  dmem_port_if.slave        p1,
  output logic [1:0]        ram_write_byte_en,
  output logic [31:0]       ram_raddr,
  output logic [31:0]       ram_waddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  p0_grant_cnt,
  output logic [CNT_W-1:0]  p1_grant_cnt,
  output logic [CNT_W-1:0]  p1_forced_cnt
`endif
);

  localparam logic [1:0] WBE_NO = 2'd0;
  localparam logic [1:0] WBE_B  = 2'd1;
  localparam logic [1:0] WBE_H  = 2'd2;
  localparam logic [1:0] WBE_W  = 2'd3;

  localparam int unsigned     WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [32:0]     SIZE_LIM = 33'(SIZE);

  if (MAX_WAIT < 1 || CNT_W < 1) begin : g_bad_param
    $error("dmem_arbiter: MAX_WAIT and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_P0,
    GNT_P1
  } grant_e;

  grant_e       grant;
  logic         forced;
  logic         sel_we;
  logic [1:0]   sel_size;
  logic [31:0]  sel_addr;
  logic [31:0]  sel_wdata;
  logic [32:0]  acc_len;
  logic         acc_err;
  logic [31:0]  acc_rdata;

  logic [WW-1:0] wait_cnt;

  logic         p0_rsp_valid_q;
  logic         p0_rsp_err_q;
  logic [31:0]  p0_rsp_rdata_q;
  logic         p1_rsp_valid_q;
  logic         p1_rsp_err_q;
  logic [31:0]  p1_rsp_rdata_q;

  // Grants are suppressed while reset is asserted so no RAM write can slip through.
  always_comb begin
    grant  = GNT_NONE;
    forced = 1'b0;
    if (rst_n) begin
      if (wait_cnt == WAIT_MAX && p1.req_valid) begin
        grant  = GNT_P1;
        forced = 1'b1;
      end else if (p0.req_valid) begin
        grant = GNT_P0;
      end else if (p1.req_valid) begin
        grant = GNT_P1;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_size  = WBE_NO;
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant)
      GNT_P0: begin
        sel_we    = p0.we;
        sel_size  = p0.size;
        sel_addr  = p0.addr;
        sel_wdata = p0.wdata;
      end
      GNT_P1: begin
        sel_we    = p1.we;
        sel_size  = p1.size;
        sel_addr  = p1.addr;
        sel_wdata = p1.wdata;
      end
      default: ;
    endcase
  end

  // Bounds check in 33 bits so an access wrapping past 0xFFFFFFFF is caught.
  always_comb begin
    acc_len = 33'd4;
    if (sel_we) begin
      case (sel_size)
        WBE_B:   acc_len = 33'd1;
        WBE_H:   acc_len = 33'd2;
        WBE_W:   acc_len = 33'd4;
        default: acc_len = 33'd0;
      endcase
    end
    acc_err   = (grant != GNT_NONE) && (({1'b0, sel_addr} + acc_len) > SIZE_LIM);
    acc_rdata = (grant != GNT_NONE && !sel_we && !acc_err) ? ram_rdata : '0;
  end

  assign p0.req_ready = (grant == GNT_P0);
  assign p1.req_ready = (grant == GNT_P1);

  assign ram_write_byte_en = (grant != GNT_NONE && sel_we && !acc_err) ? sel_size : WBE_NO;
  assign ram_raddr         = sel_addr;
  assign ram_waddr         = sel_addr;
  assign ram_wdata         = sel_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (p1.req_valid && grant != GNT_P1) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_valid_q <= 1'b0;
      p0_rsp_err_q   <= 1'b0;
      p0_rsp_rdata_q <= '0;
      p1_rsp_valid_q <= 1'b0;
      p1_rsp_err_q   <= 1'b0;
      p1_rsp_rdata_q <= '0;
    end else begin
      p0_rsp_valid_q <= (grant == GNT_P0);
      p0_rsp_err_q   <= (grant == GNT_P0) && acc_err;
      p0_rsp_rdata_q <= (grant == GNT_P0) ? acc_rdata : '0;
      p1_rsp_valid_q <= (grant == GNT_P1);
      p1_rsp_err_q   <= (grant == GNT_P1) && acc_err;
      p1_rsp_rdata_q <= (grant == GNT_P1) ? acc_rdata : '0;
    end
  end

  assign p0.rsp_valid = p0_rsp_valid_q;
  assign p0.rsp_err   = p0_rsp_err_q;
  assign p0.rsp_rdata = p0_rsp_rdata_q;
  assign p1.rsp_valid = p1_rsp_valid_q;
  assign p1.rsp_err   = p1_rsp_err_q;
  assign p1.rsp_rdata = p1_rsp_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_grant_cnt  <= '0;
      p1_grant_cnt  <= '0;
      p1_forced_cnt <= '0;
    end else begin
      if (grant == GNT_P0 && p0_grant_cnt != '1) begin
        p0_grant_cnt <= p0_grant_cnt + CNT_W'(1);
      end
      if (grant == GNT_P1 && p1_grant_cnt != '1) begin
        p1_grant_cnt <= p1_grant_cnt + CNT_W'(1);
      end
      if (forced && p1_forced_cnt != '1) begin
        p1_forced_cnt <= p1_forced_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference arbiter/memory model predicts grants,
// RAM drive and responses; expected responses are queued at accept and popped on rsp_valid.
module tb_dmem_arbiter;
  localparam int unsigned SIZE     = 1024;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 16;

  localparam logic [1:0] WBE_NO = 2'd0;
  localparam logic [1:0] WBE_B  = 2'd1;
  localparam logic [1:0] WBE_H  = 2'd2;
  localparam logic [1:0] WBE_W  = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  dmem_port_if p0_bus ();
  dmem_port_if p1_bus ();

  logic [1:0]  ram_write_byte_en;
  logic [31:0] ram_raddr, ram_waddr, ram_wdata, ram_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] p0_grant_cnt, p1_grant_cnt, p1_forced_cnt;
`endif

  dmem_arbiter #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .p0                (p0_bus),
    .p1                (p1_bus),
    .ram_write_byte_en (ram_write_byte_en),
    .ram_raddr         (ram_raddr),
    .ram_waddr         (ram_waddr),
    .ram_wdata         (ram_wdata),
    .ram_rdata         (ram_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .p0_grant_cnt      (p0_grant_cnt),
    .p1_grant_cnt      (p1_grant_cnt),
    .p1_forced_cnt     (p1_forced_cnt)
`endif
  );

  function automatic int unsigned wbe_len(logic we, logic [1:0] sz);
    if (!we) return 4;
    case (sz)
      WBE_B:   return 1;
      WBE_H:   return 2;
      WBE_W:   return 4;
      default: return 0;
    endcase
  endfunction

  // Bench-side RAM: writes land at the clock edge, reads are combinational.
  logic [7:0] ram [0:SIZE-1];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < int'(SIZE); i++) ram[i] <= 8'h00;
    end else begin
      for (int k = 0; k < int'(wbe_len(1'b1, ram_write_byte_en)); k++) begin
        if (ram_waddr + 32'(k) < SIZE) ram[10'(ram_waddr + 32'(k))] <= ram_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    ram_rdata = '0;
    if (ram_raddr <= SIZE - 4) begin
      for (int k = 0; k < 4; k++) ram_rdata[8*k +: 8] = ram[10'(ram_raddr + 32'(k))];
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mmem [0:SIZE-1];
  int unsigned m_wait = 0;
  int unsigned cyc = 0;
  int          last_g = -1;
  logic        dut_r0, dut_r1;
  int unsigned m_cnt0 = 0, m_cnt1 = 0, m_forced = 0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic we, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_bus.req_valid = v; p0_bus.we = we; p0_bus.size = sz;
      p0_bus.addr = addr;   p0_bus.wdata = wdata;
    end else begin
      p1_bus.req_valid = v; p1_bus.we = we; p1_bus.size = sz;
      p1_bus.addr = addr;   p1_bus.wdata = wdata;
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, WBE_NO, '0, '0);
    set_req(1, 1'b0, 1'b0, WBE_NO, '0, '0);
  endtask

  // Called just after a falling edge with inputs already driven; ends after the clock edge.
  task automatic pre_and_edge();
    int          g;
    logic        forced, s_we, s_err;
    logic [1:0]  s_size, e_wbe;
    logic [31:0] s_addr, s_wdata, e_rd;
    logic [32:0] endp;
    exp_t        e;
    #1;
    forced = (m_wait == MAX_WAIT) && p1_bus.req_valid;
    if (forced)                g = 1;
    else if (p0_bus.req_valid) g = 0;
    else if (p1_bus.req_valid) g = 1;
    else                       g = -1;
    s_we = 1'b0; s_size = WBE_NO; s_addr = '0; s_wdata = '0;
    if (g == 0) begin
      s_we = p0_bus.we; s_size = p0_bus.size; s_addr = p0_bus.addr; s_wdata = p0_bus.wdata;
    end else if (g == 1) begin
      s_we = p1_bus.we; s_size = p1_bus.size; s_addr = p1_bus.addr; s_wdata = p1_bus.wdata;
    end
    endp  = {1'b0, s_addr} + 33'(wbe_len(s_we, s_size));
    s_err = (g >= 0) && (endp > 33'(SIZE));
    e_wbe = (g >= 0 && s_we && !s_err) ? s_size : WBE_NO;
    e_rd  = '0;
    if (g >= 0 && !s_we && !s_err)
      for (int k = 0; k < 4; k++) e_rd[8*k +: 8] = mmem[10'(s_addr + 32'(k))];
    dut_r0 = p0_bus.req_ready;
    dut_r1 = p1_bus.req_ready;
    check("p0_req_ready", dut_r0, g == 0);
    check("p1_req_ready", dut_r1, g == 1);
    check("ram_write_byte_en", ram_write_byte_en, e_wbe);
    check("ram_raddr", ram_raddr, s_addr);
    check("ram_waddr", ram_waddr, s_addr);
    check("ram_wdata", ram_wdata, s_wdata);
    last_g = g;
    @(posedge clk);
    for (int k = 0; k < int'(wbe_len(1'b1, e_wbe)); k++) mmem[10'(s_addr + 32'(k))] = s_wdata[8*k +: 8];
    if (p1_bus.req_valid && g != 1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
    else                            m_wait = 0;
    if (g == 0) m_cnt0++;
    if (g == 1) m_cnt1++;
    if (forced) m_forced++;
    e.rd = e_rd; e.err = s_err; e.due = cyc + 1;
    if (g == 0) q0.push_back(e);
    if (g == 1) q1.push_back(e);
    cyc++;
  endtask

  task automatic check_rsp();
    exp_t e;
    logic ev0, ev1;
    ev0 = (q0.size() > 0) && (q0[0].due == cyc);
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    check("p0_rsp_valid", p0_bus.rsp_valid, ev0);
    check("p1_rsp_valid", p1_bus.rsp_valid, ev1);
    if (ev0) begin
      e = q0.pop_front();
      check("p0_rsp_rdata", p0_bus.rsp_rdata, e.rd);
      check("p0_rsp_err", p0_bus.rsp_err, e.err);
    end
    if (ev1) begin
      e = q1.pop_front();
      check("p1_rsp_rdata", p1_bus.rsp_rdata, e.rd);
      check("p1_rsp_err", p1_bus.rsp_err, e.err);
    end
  endtask

  task automatic do_cycle();
    pre_and_edge();
    @(negedge clk);
    check_rsp();
  endtask

  task automatic rand_req(input int port);
    logic [31:0] a;
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 0)      a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    else if (r == 1) a = SIZE - 4 + 32'($urandom_range(0, 7));
    else             a = 32'($urandom_range(0, 63));
    set_req(port, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), a, $urandom);
  endtask

  initial begin
    for (int i = 0; i < int'(SIZE); i++) mmem[i] = 8'h00;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    check("reset_p0_rsp_valid", p0_bus.rsp_valid, 1'b0);
    check("reset_p1_rsp_valid", p1_bus.rsp_valid, 1'b0);
    check("reset_p0_rsp_err", p0_bus.rsp_err, 1'b0);
    check("reset_p1_rsp_err", p1_bus.rsp_err, 1'b0);
    check("reset_p0_rsp_rdata", p0_bus.rsp_rdata, 32'h0);
    check("reset_p1_rsp_rdata", p1_bus.rsp_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    check("reset_p1_forced_cnt", 32'(p1_forced_cnt), 32'h0);
`endif
    rst_n = 1'b1;

    // Word write then read-back on the next cycle
    set_req(0, 1'b1, 1'b1, WBE_W, 32'h10, 32'hDEAD_BEEF);
    do_cycle();
    set_req(0, 1'b1, 1'b0, WBE_NO, 32'h10, '0);
    do_cycle();
    check("t1_readback", p0_bus.rsp_rdata, 32'hDEAD_BEEF);

    // Byte overwrite inside the word
    set_req(0, 1'b1, 1'b1, WBE_B, 32'h11, 32'h0000_0055);
    do_cycle();
    set_req(0, 1'b1, 1'b0, WBE_NO, 32'h10, '0);
    do_cycle();
    check("t2_readback", p0_bus.rsp_rdata, 32'hDEAD_55EF);
    idle_all();
    do_cycle();

    // Continuous contention: p1 forced through every fifth cycle
    set_req(0, 1'b1, 1'b0, WBE_NO, 32'h10, '0);
    set_req(1, 1'b1, 1'b0, WBE_NO, 32'h20, '0);
    for (int i = 0; i < 15; i++) begin
      do_cycle();
      check("arb_pattern_p1", dut_r1, (i % 5) == 4);
    end
`ifdef DMEM_ARB_STATS_EN
    check("p1_forced_cnt", 32'(p1_forced_cnt), 32'(m_forced));
    check("p0_grant_cnt", 32'(p0_grant_cnt), 32'(m_cnt0));
`endif
    idle_all();
    do_cycle();

    // Boundary accesses on p1
    set_req(1, 1'b1, 1'b0, WBE_NO, 32'd1021, '0);
    do_cycle();
    check("t5_read1021_err", p1_bus.rsp_err, 1'b1);
    check("t5_read1021_rdata", p1_bus.rsp_rdata, 32'h0);
    set_req(1, 1'b1, 1'b1, WBE_H, 32'd1022, 32'h0000_A5C3);
    do_cycle();
    check("t5_writeH1022_err", p1_bus.rsp_err, 1'b0);
    set_req(1, 1'b1, 1'b0, WBE_NO, 32'd1020, '0);
    do_cycle();
    check("t5_read1020", p1_bus.rsp_rdata, 32'hA5C3_0000);
    set_req(1, 1'b1, 1'b1, WBE_W, 32'hFFFF_FFFE, 32'h1234_5678);
    do_cycle();
    check("t5_wrap_err", p1_bus.rsp_err, 1'b1);
    set_req(1, 1'b1, 1'b1, WBE_NO, 32'h40, 32'hFFFF_FFFF);
    do_cycle();
    check("t5_wbe_no_err", p1_bus.rsp_err, 1'b0);

    // Lone p1 requester is accepted immediately every cycle
    idle_all();
    do_cycle();
    set_req(1, 1'b1, 1'b0, WBE_NO, 32'h20, '0);
    for (int i = 0; i < 6; i++) begin
      do_cycle();
      check("lone_p1_ready", dut_r1, 1'b1);
    end
    idle_all();
    do_cycle();

    // Reset in the cycle after a p0 read accept, with a write held during reset
    set_req(0, 1'b1, 1'b0, WBE_NO, 32'h10, '0);
    pre_and_edge();
    #2;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b1, WBE_W, 32'h10, 32'h1234_5678);
    #1;
    check("rst_p0_rsp_valid", p0_bus.rsp_valid, 1'b0);
    check("rst_ram_wbe", ram_write_byte_en, WBE_NO);
    check("rst_p0_ready", p0_bus.req_ready, 1'b0);
    q0.delete();
    q1.delete();
    m_wait = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_p0_rsp_valid_hold", p0_bus.rsp_valid, 1'b0);
    for (int k = 0; k < 4; k++) check("rst_no_ram_write", ram[16 + k], mmem[16 + k]);
    idle_all();
    rst_n = 1'b1;
`ifdef DMEM_ARB_STATS_EN
    m_cnt0 = 0; m_cnt1 = 0; m_forced = 0;
`endif
    do_cycle();
    set_req(0, 1'b1, 1'b0, WBE_NO, 32'h10, '0);
    do_cycle();
    check("post_rst_read", p0_bus.rsp_rdata, 32'hDEAD_55EF);

    // Random mixed traffic; a refused requester holds its request
    for (int i = 0; i < 400; i++) begin
      if (!p0_bus.req_valid || last_g == 0) rand_req(0);
      if (!p1_bus.req_valid || last_g == 1) rand_req(1);
      do_cycle();
    end
    idle_all();
    do_cycle();
`ifdef DMEM_ARB_STATS_EN
    check("end_p0_grant_cnt", 32'(p0_grant_cnt), 32'(m_cnt0));
    check("end_p1_grant_cnt", 32'(p1_grant_cnt), 32'(m_cnt1));
    check("end_p1_forced_cnt", 32'(p1_forced_cnt), 32'(m_forced));
`endif
    check("end_q0_drained", q0.size(), 32'd0);
    check("end_q1_drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressable data RAM.
- Port 0 is the CPU load/store path; port 1 is the debug/loader port.
- Picks one access per cycle, drives the RAM write-enable code and addresses, registers read data into a one-cycle response, and flags out-of-range accesses.
- Starvation counter guarantees port 1 forward progress under continuous CPU traffic.

Parameters:
- SIZE, 1024, RAM size in bytes; used for bounds checking.
- MAX_WAIT, 4, cycles port 1 may be refused before it gets priority; legal range >= 1.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid  in  1  port 0 request
- p0_req_ready  out  1  port 0 accepted this cycle (combinational)
- p0_we  in  1  1 = write, 0 = read
- p0_size  in  2  write width code: WBE_NO / WBE_B / WBE_H / WBE_W from sr_cpu.svh
- p0_addr  in  32  byte address
- p0_wdata  in  32  write data, LSB-aligned
- p0_rsp_valid  out  1  response pulse
- p0_rsp_rdata  out  32  read word; 0 for writes and errors
- p0_rsp_err  out  1  out-of-range access
- p1_*  same set as p0_*  port 1
- ram_write_byte_en  out  2  to RAM write_byte_en
- ram_raddr  out  32  to RAM raddr
- ram_waddr  out  32  to RAM waddr
- ram_wdata  out  32  to RAM wdata
- ram_rdata  in  32  from RAM rdata (combinational read)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all rsp_valid/rsp_err = 0, rsp_rdata = 0, wait_cnt = 0, stats counters = 0.
- Ready signals are combinational. A request is accepted on valid && ready. A requester holds its request stable while valid && !ready.
- Grant priority:
  - If wait_cnt == MAX_WAIT and p1_req_valid: grant p1.
  - Else if p0_req_valid: grant p0.
  - Else if p1_req_valid: grant p1.
  - Else: no grant.
- At most one grant per cycle.
- wait_cnt update:
  - +1, saturating at MAX_WAIT, when p1_req_valid && !p1_req_ready.
  - Cleared on p1 accept, or when p1_req_valid == 0.
- Access length: reads are 4 bytes. Writes are 1/2/4 bytes for WBE_B/WBE_H/WBE_W and 0 bytes for WBE_NO.
- Error condition: addr + length > SIZE, computed in 33 bits so wrap near 0xFFFFFFFF is caught.
- RAM drive for a granted access:
  - ram_raddr = ram_waddr = granted addr; ram_wdata = granted wdata.
  - ram_write_byte_en = size when we && !err; otherwise WBE_NO.
- RAM drive with no grant: ram_write_byte_en = WBE_NO; addresses and data = 0.
- A granted write with WBE_NO is a no-op with a normal (error-free) response.
- Latency: response arrives exactly 1 cycle after acceptance, on the accepting port only.
  - rsp_valid is a 1-cycle pulse.
  - rsp_rdata = ram_rdata sampled at the accept edge for error-free reads; otherwise 0.
  - rsp_err = err.
- Back-to-back: a new accept is allowed every cycle, so responses may pulse on consecutive cycles.
- A write to the RAM lands at the accept edge, so a read of the same bytes accepted in the next cycle returns the new data.
- Reset mid-operation: pending responses are dropped; the first cycle after reset release behaves as idle.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, the block adds three output ports, each CNT_W wide:
  - p0_grant_cnt: count of port 0 accepts.
  - p1_grant_cnt: count of port 1 accepts.
  - p1_forced_cnt: count of grants taken because wait_cnt == MAX_WAIT.
- All three counters saturate at all-ones and reset to 0.
- When not defined, these ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- p0 write WBE_W addr 0x10 data 0xDEADBEEF, next cycle p0 read 0x10 -> ram_write_byte_en=WBE_W in cycle 0; p0_rsp_valid pulses in cycles 1 and 2; second response rdata=0xDEADBEEF, err=0.
- p0 WBE_B write 0x55 to 0x11 over the word above, then read 0x10 -> rdata=0xDEAD55EF.
- p0 and p1 both valid continuously, MAX_WAIT=4 -> p0 granted 4 cycles, p1 granted in cycle 5; pattern repeats every 5 cycles; p1_forced_cnt increments each period with stats enabled.
- p1 read addr 1021 (SIZE=1024) -> rsp_err=1, rdata=0; p1 write WBE_H at 1022 -> err=0, bytes written; write WBE_W at 0xFFFFFFFE -> err=1, ram_write_byte_en stays WBE_NO.
- Only p1 valid -> p1_req_ready=1 same cycle, wait_cnt stays 0.
- Assert rst_n low the cycle after a p0 read accept -> p0_rsp_valid=0 immediately and stays 0 after release; no RAM write occurs during reset.
